ctrl_pipe_hazard: RTL and testbench
===================================

# ctrl_pipe_hazard

Consumer-side companion to the instruction control decoder in the 5-stage RV64 subset core (ld, sd, addi, R-format, beq). Takes the decoder's per-instruction control bits in ID and carries them through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and taken branches, generating stall/flush. Computes EX-stage operand forwarding selects.

## Interface
- No parameters. Register index width is fixed at 5, ALUOp at 2.
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- ALUSrc_i, MemWr_i, Branch_i, MemtoReg_i, RegWr_i  in  1 each  ID-stage control bits from decoder
- ALUOp_i  in  2  ID-stage ALUOp (00 ld/sd, 01 beq, 10 R, 11 addi)
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  ID-stage register fields
- ex_zero_i  in  1  ALU zero flag of instruction in EX
- ex_ALUSrc_o  out  1;  ex_ALUOp_o  out  2  EX controls
- mem_MemWr_o  out  1  MEM-stage store enable
- wb_MemtoReg_o, wb_RegWr_o  out  1 each;  wb_rd_o  out  5  WB controls/destination
- stall_o  out  1  hold PC and IF/ID this cycle
- flush_o  out  1  taken branch in EX; squash IF/ID
- fwd_a_o, fwd_b_o  out  2 each  EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result

## Operation
- Stage registers hold: ID/EX {ALUSrc, ALUOp, MemWr, Branch, MemtoReg, RegWr, rs1, rs2, rd}; EX/MEM {MemWr, MemtoReg, RegWr, rd}; MEM/WB {MemtoReg, RegWr, rd}.
- A bubble is all control bits 0, rd = 0. Register fields in bubbles are don't-care but are driven to 0.
- rs2_used = ~ALUSrc_i | MemWr_i (R-format, beq, sd). rs1 is always used.
- Load-use: ld_hz = idex.MemtoReg & idex.RegWr & (idex.rd != 0) & ((idex.rd == id_rs1_i) | (rs2_used & idex.rd == id_rs2_i)).
- Branch taken: br_tk = idex.Branch & ex_zero_i.
- flush_o = br_tk. stall_o = ld_hz & ~br_tk. Flush has priority because the stalled ID instruction is on the wrong path.
- ID/EX next value: bubble if br_tk or ld_hz, otherwise the ID inputs.
- EX/MEM and MEM/WB always advance; they are never held.
- Forward A: 10 if exmem.RegWr & exmem.rd != 0 & exmem.rd == idex.rs1. Otherwise 01 if the same test passes against memwb. Otherwise 00. Forward B uses the same rule against idex.rs2.
- EX/MEM takes priority on a double match. rd = x0 never forwards or stalls.
- WB→ID same-cycle bypass is out of scope; the regfile is write-first.

## Timing
- Reset: every stage register clears to bubble. All outputs are 0 in the cycle after rst_i is sampled high.
- rst_i asserted mid-stream discards all in-flight controls at that edge. No pending write survives.
- stall_o, flush_o and fwd_*_o are combinational from current stage registers and ID inputs, with zero latency.
- ID input reaches ex_* outputs after 1 edge, mem_MemWr_o after 2 edges, and wb_* outputs after 3 edges.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and a bubble is in EX, so ld_hz = 0. The consumer then issues and takes fwd = 01 from MEM/WB.
- When ld_hz and br_tk coincide: flush_o = 1, stall_o = 0, and ID/EX becomes a bubble.
- Back-to-back taken branches each flush independently.

## Test plan
- Reset: hold rst_i 2 cycles with RegWr_i = 1. Required: all outputs are 0. After release, feed addi x5; wb_RegWr_o = 1 and wb_rd_o = 5 exactly 3 edges later.
- EX/MEM forward: add x3,x1,x2 then sub x4,x3,x3. Required: while sub is in EX, fwd_a_o = fwd_b_o = 10 and stall_o = 0.
- Priority: addi x6, addi x6, add x7,x6,x0. Required: fwd_a_o = 10 (newest). With only the older producer in flight, fwd_a_o = 01.
- Load-use: ld x8 then add x9,x8,x1. Required: stall_o = 1 for exactly 1 cycle, then a bubble in EX (ex_ALUOp_o = 00, RegWr = 0), then fwd_a_o = 01.
  - ld x8 then sd x8 as rs2: stalls.
  - ld x8 then addi x9,x1 with rs2 field = 8: no stall.
- Branch: beq with ex_zero_i = 1 while ld-use is pending in ID. Required: flush_o = 1, stall_o = 0, and the next-cycle EX holds a bubble. With ex_zero_i = 0: flush_o = 0.
- x0: ld x0 then add x1,x0,x0. Required: no stall and fwd = 00.

Source files
------------

// File: rtl/ctrl_pipe_hazard.sv
// Control-side pipeline for the 5-stage RV64 subset core: carries decoder control bits
// through ID/EX, EX/MEM and MEM/WB, and produces load-use stall, branch flush and EX forwarding selects.
module ctrl_pipe_hazard (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ALUSrc_i,
    input  logic       MemWr_i,
    input  logic       Branch_i,
    input  logic       MemtoReg_i,
    input  logic       RegWr_i,
    input  logic [1:0] ALUOp_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic [4:0] id_rd_i,
    input  logic       ex_zero_i,
    output logic       ex_ALUSrc_o,
    output logic [1:0] ex_ALUOp_o,
    output logic       mem_MemWr_o,
    output logic       wb_MemtoReg_o,
    output logic       wb_RegWr_o,
    output logic [4:0] wb_rd_o,
    output logic       stall_o,
    output logic       flush_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    logic       idex_alusrc_r;
    logic       idex_memwr_r;
    logic       idex_branch_r;
    logic       idex_memtoreg_r;
    logic       idex_regwr_r;
    logic [1:0] idex_aluop_r;
    logic [4:0] idex_rs1_r;
    logic [4:0] idex_rs2_r;
    logic [4:0] idex_rd_r;

    logic       exmem_memwr_r;
    logic       exmem_memtoreg_r;
    logic       exmem_regwr_r;
    logic [4:0] exmem_rd_r;

    logic       memwb_memtoreg_r;
    logic       memwb_regwr_r;
    logic [4:0] memwb_rd_r;

    logic       rs2_used_s;
    logic       ld_hz_s;
    logic       br_tk_s;
    logic       bubble_s;

    // Newer producer (EX/MEM) wins over the older one (MEM/WB); x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       em_wr,
        input logic [4:0] em_rd,
        input logic       mw_wr,
        input logic [4:0] mw_rd
    );
        if (em_wr && (em_rd != 5'd0) && (em_rd == rs)) begin
            return 2'b10;
        end else if (mw_wr && (mw_rd != 5'd0) && (mw_rd == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Load-use and taken-branch detection from the ID/EX entry and the ID fields
    always_comb begin
        rs2_used_s = ~ALUSrc_i | MemWr_i;
        ld_hz_s    = idex_memtoreg_r & idex_regwr_r & (idex_rd_r != 5'd0) &
                     ((idex_rd_r == id_rs1_i) | (rs2_used_s & (idex_rd_r == id_rs2_i)));
        br_tk_s    = idex_branch_r & ex_zero_i;
        bubble_s   = ld_hz_s | br_tk_s;
    end

    // Flush outranks stall: the stalled ID instruction is on the wrong path anyway.
    assign flush_o = br_tk_s;
    assign stall_o = ld_hz_s & ~br_tk_s;
    assign fwd_a_o = fwd_sel(idex_rs1_r, exmem_regwr_r, exmem_rd_r, memwb_regwr_r, memwb_rd_r);
    assign fwd_b_o = fwd_sel(idex_rs2_r, exmem_regwr_r, exmem_rd_r, memwb_regwr_r, memwb_rd_r);

    assign ex_ALUSrc_o   = idex_alusrc_r;
    assign ex_ALUOp_o    = idex_aluop_r;
    assign mem_MemWr_o   = exmem_memwr_r;
    assign wb_MemtoReg_o = memwb_memtoreg_r;
    assign wb_RegWr_o    = memwb_regwr_r;
    assign wb_rd_o       = memwb_rd_r;

    // Stage registers: ID/EX takes a bubble on hazard or flush, later stages always advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_alusrc_r    <= 1'b0;
            idex_memwr_r     <= 1'b0;
            idex_branch_r    <= 1'b0;
            idex_memtoreg_r  <= 1'b0;
            idex_regwr_r     <= 1'b0;
            idex_aluop_r     <= 2'b00;
            idex_rs1_r       <= 5'd0;
            idex_rs2_r       <= 5'd0;
            idex_rd_r        <= 5'd0;
            exmem_memwr_r    <= 1'b0;
            exmem_memtoreg_r <= 1'b0;
            exmem_regwr_r    <= 1'b0;
            exmem_rd_r       <= 5'd0;
            memwb_memtoreg_r <= 1'b0;
            memwb_regwr_r    <= 1'b0;
            memwb_rd_r       <= 5'd0;
        end else begin
            if (bubble_s) begin
                idex_alusrc_r   <= 1'b0;
                idex_memwr_r    <= 1'b0;
                idex_branch_r   <= 1'b0;
                idex_memtoreg_r <= 1'b0;
                idex_regwr_r    <= 1'b0;
                idex_aluop_r    <= 2'b00;
                idex_rs1_r      <= 5'd0;
                idex_rs2_r      <= 5'd0;
                idex_rd_r       <= 5'd0;
            end else begin
                idex_alusrc_r   <= ALUSrc_i;
                idex_memwr_r    <= MemWr_i;
                idex_branch_r   <= Branch_i;
                idex_memtoreg_r <= MemtoReg_i;
                idex_regwr_r    <= RegWr_i;
                idex_aluop_r    <= ALUOp_i;
                idex_rs1_r      <= id_rs1_i;
                idex_rs2_r      <= id_rs2_i;
                idex_rd_r       <= id_rd_i;
            end
            exmem_memwr_r    <= idex_memwr_r;
            exmem_memtoreg_r <= idex_memtoreg_r;
            exmem_regwr_r    <= idex_regwr_r;
            exmem_rd_r       <= idex_rd_r;
            memwb_memtoreg_r <= exmem_memtoreg_r;
            memwb_regwr_r    <= exmem_regwr_r;
            memwb_rd_r       <= exmem_rd_r;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: directed scenarios followed by random traffic, all checked
// against an instruction-level pipeline model (a 3-entry array of in-flight instructions).
module tb_ctrl_pipe_hazard;

    typedef struct packed {
        logic       alusrc;
        logic       memwr;
        logic       branch;
        logic       memtoreg;
        logic       regwr;
        logic [1:0] aluop;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ins_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       ALUSrc_i = 1'b0, MemWr_i = 1'b0, Branch_i = 1'b0, MemtoReg_i = 1'b0, RegWr_i = 1'b0;
    logic [1:0] ALUOp_i = 2'b00;
    logic [4:0] id_rs1_i = 5'd0, id_rs2_i = 5'd0, id_rd_i = 5'd0;
    logic       ex_zero_i = 1'b0;
    logic       ex_ALUSrc_o, mem_MemWr_o, wb_MemtoReg_o, wb_RegWr_o, stall_o, flush_o;
    logic [1:0] ex_ALUOp_o, fwd_a_o, fwd_b_o;
    logic [4:0] wb_rd_o;

    int   n_err = 0;
    int   n_checks = 0;
    ins_t cur;
    ins_t pipe [3];   // [0] in EX, [1] in MEM, [2] in WB

    ctrl_pipe_hazard dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUSrc_i(ALUSrc_i), .MemWr_i(MemWr_i), .Branch_i(Branch_i),
        .MemtoReg_i(MemtoReg_i), .RegWr_i(RegWr_i), .ALUOp_i(ALUOp_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .ex_zero_i(ex_zero_i),
        .ex_ALUSrc_o(ex_ALUSrc_o), .ex_ALUOp_o(ex_ALUOp_o), .mem_MemWr_o(mem_MemWr_o),
        .wb_MemtoReg_o(wb_MemtoReg_o), .wb_RegWr_o(wb_RegWr_o), .wb_rd_o(wb_rd_o),
        .stall_o(stall_o), .flush_o(flush_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic ins_t mk(input logic a, input logic mw, input logic b, input logic m2r,
                                input logic rw, input logic [1:0] op,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        ins_t i;
        i = {a, mw, b, m2r, rw, op, rs1, rs2, rd};
        return i;
    endfunction

    function automatic ins_t i_ld(input logic [4:0] rd, input logic [4:0] rs1);
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, rs1, 5'd0, rd);
    endfunction
    function automatic ins_t i_sd(input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, rs1, rs2, 5'd0);
    endfunction
    function automatic ins_t i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, rs1, rs2f, rd);
    endfunction
    function automatic ins_t i_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, rs1, rs2, rd);
    endfunction
    function automatic ins_t i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, rs1, rs2, 5'd0);
    endfunction

    // Model: the instruction in EX is a load whose result the ID instruction reads
    function automatic logic m_ldhz();
        logic reads_rs2;
        reads_rs2 = !cur.alusrc || cur.memwr;
        return pipe[0].memtoreg && pipe[0].regwr && (pipe[0].rd != 5'd0) &&
               ((pipe[0].rd == cur.rs1) || (reads_rs2 && (pipe[0].rd == cur.rs2)));
    endfunction

    function automatic logic m_brtk();
        return pipe[0].branch && ex_zero_i;
    endfunction

    // Model: youngest older writer of rs wins; MEM -> 10, WB -> 01
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].regwr && (pipe[k].rd != 5'd0) && (pipe[k].rd == rs))
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input ins_t i, input logic z);
        cur        = i;
        ALUSrc_i   = i.alusrc;
        MemWr_i    = i.memwr;
        Branch_i   = i.branch;
        MemtoReg_i = i.memtoreg;
        RegWr_i    = i.regwr;
        ALUOp_i    = i.aluop;
        id_rs1_i   = i.rs1;
        id_rs2_i   = i.rs2;
        id_rd_i    = i.rd;
        ex_zero_i  = z;
        #1;
    endtask

    task automatic check_model();
        chk("m_ex_alusrc", {7'd0, ex_ALUSrc_o}, {7'd0, pipe[0].alusrc});
        chk("m_ex_aluop", {6'd0, ex_ALUOp_o}, {6'd0, pipe[0].aluop});
        chk("m_mem_memwr", {7'd0, mem_MemWr_o}, {7'd0, pipe[1].memwr});
        chk("m_wb_memtoreg", {7'd0, wb_MemtoReg_o}, {7'd0, pipe[2].memtoreg});
        chk("m_wb_regwr", {7'd0, wb_RegWr_o}, {7'd0, pipe[2].regwr});
        chk("m_wb_rd", {3'd0, wb_rd_o}, {3'd0, pipe[2].rd});
        chk("m_flush", {7'd0, flush_o}, {7'd0, m_brtk()});
        chk("m_stall", {7'd0, stall_o}, {7'd0, m_ldhz() && !m_brtk()});
        chk("m_fwd_a", {6'd0, fwd_a_o}, {6'd0, m_fwd(pipe[0].rs1)});
        chk("m_fwd_b", {6'd0, fwd_b_o}, {6'd0, m_fwd(pipe[0].rs2)});
    endtask

    // One clock edge: update the model with what the pipeline should have captured
    task automatic advance();
        logic squash;
        squash = m_ldhz() || m_brtk();
        @(posedge clk_i);
        if (rst_i) begin
            pipe[0] = '0;
            pipe[1] = '0;
            pipe[2] = '0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = squash ? ins_t'('0) : cur;
        end
        @(negedge clk_i);
    endtask

    initial begin
        pipe[0] = '0;
        pipe[1] = '0;
        pipe[2] = '0;
        cur     = '0;

        // Reset held two cycles with a writer sitting in ID
        rst_i = 1'b1;
        drive(i_addi(5'd5, 5'd0, 5'd0), 1'b0);
        advance();
        advance();
        drive(i_addi(5'd5, 5'd0, 5'd0), 1'b0);
        check_model();
        chk("rst_wb_regwr", {7'd0, wb_RegWr_o}, 8'd0);
        chk("rst_ex_aluop", {6'd0, ex_ALUOp_o}, 8'd0);
        chk("rst_stall", {7'd0, stall_o}, 8'd0);
        chk("rst_fwd_a", {6'd0, fwd_a_o}, 8'd0);
        rst_i = 1'b0;
        advance();
        drive('0, 1'b0);
        chk("addi_ex_aluop", {6'd0, ex_ALUOp_o}, 8'd3);
        advance();
        drive('0, 1'b0);
        chk("addi_wb_early", {7'd0, wb_RegWr_o}, 8'd0);
        advance();
        drive('0, 1'b0);
        check_model();
        chk("addi_wb_regwr", {7'd0, wb_RegWr_o}, 8'd1);
        chk("addi_wb_rd", {3'd0, wb_rd_o}, 8'd5);

        // EX/MEM forwarding to both operands
        drive(i_r(5'd3, 5'd1, 5'd2), 1'b0); advance();
        drive(i_r(5'd4, 5'd3, 5'd3), 1'b0); advance();
        drive('0, 1'b0);
        check_model();
        chk("exmem_fwd_a", {6'd0, fwd_a_o}, 8'h02);
        chk("exmem_fwd_b", {6'd0, fwd_b_o}, 8'h02);
        chk("exmem_stall", {7'd0, stall_o}, 8'd0);
        advance();

        // Double match takes the newer producer; lone older producer forwards from MEM/WB
        drive(i_addi(5'd6, 5'd0, 5'd0), 1'b0); advance();
        drive(i_addi(5'd6, 5'd0, 5'd0), 1'b0); advance();
        drive(i_r(5'd7, 5'd6, 5'd0), 1'b0); advance();
        drive('0, 1'b0);
        chk("prio_fwd_a", {6'd0, fwd_a_o}, 8'h02);
        advance();
        drive(i_addi(5'd6, 5'd0, 5'd0), 1'b0); advance();
        drive('0, 1'b0); advance();
        drive(i_r(5'd7, 5'd6, 5'd0), 1'b0); advance();
        drive('0, 1'b0);
        chk("older_fwd_a", {6'd0, fwd_a_o}, 8'h01);
        advance();

        // Load-use: one stall cycle, bubble in EX, then forward from MEM/WB
        drive(i_ld(5'd8, 5'd1), 1'b0); advance();
        drive(i_r(5'd9, 5'd8, 5'd1), 1'b0);
        check_model();
        chk("lu_stall1", {7'd0, stall_o}, 8'd1);
        advance();
        drive(i_r(5'd9, 5'd8, 5'd1), 1'b0);
        check_model();
        chk("lu_stall2", {7'd0, stall_o}, 8'd0);
        chk("lu_bubble_aluop", {6'd0, ex_ALUOp_o}, 8'd0);
        chk("lu_bubble_alusrc", {7'd0, ex_ALUSrc_o}, 8'd0);
        advance();
        drive('0, 1'b0);
        chk("lu_fwd_a", {6'd0, fwd_a_o}, 8'h01);
        advance();
        drive(i_ld(5'd8, 5'd1), 1'b0); advance();
        drive(i_sd(5'd1, 5'd8), 1'b0);
        chk("lu_sd_stall", {7'd0, stall_o}, 8'd1);
        advance();
        drive(i_ld(5'd8, 5'd1), 1'b0); advance();
        drive(i_addi(5'd9, 5'd1, 5'd8), 1'b0);
        chk("lu_addi_nostall", {7'd0, stall_o}, 8'd0);
        advance();

        // Taken branch coinciding with a load-use pattern (synthetic load+branch word in EX)
        drive(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 5'd1, 5'd2, 5'd8), 1'b0); advance();
        drive(i_r(5'd9, 5'd8, 5'd1), 1'b1);
        check_model();
        chk("br_flush", {7'd0, flush_o}, 8'd1);
        chk("br_stall", {7'd0, stall_o}, 8'd0);
        advance();
        drive('0, 1'b0);
        chk("br_bubble_aluop", {6'd0, ex_ALUOp_o}, 8'd0);
        advance();
        drive(i_beq(5'd1, 5'd2), 1'b0); advance();
        drive('0, 1'b0);
        chk("br_nottaken", {7'd0, flush_o}, 8'd0);
        advance();

        // x0 never stalls or forwards
        drive(i_ld(5'd0, 5'd1), 1'b0); advance();
        drive(i_r(5'd1, 5'd0, 5'd0), 1'b0);
        chk("x0_stall", {7'd0, stall_o}, 8'd0);
        advance();
        drive('0, 1'b0);
        chk("x0_fwd_a", {6'd0, fwd_a_o}, 8'd0);
        chk("x0_fwd_b", {6'd0, fwd_b_o}, 8'd0);
        advance();

        // Random traffic against the model, including occasional mid-stream reset
        for (int n = 0; n < 600; n++) begin
            ins_t       ri;
            logic [4:0] ra, rb, rc;
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rc = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0: ri = i_ld(rc, ra);
                1: ri = i_sd(ra, rb);
                2: ri = i_addi(rc, ra, rb);
                3: ri = i_r(rc, ra, rb);
                4: ri = i_beq(ra, rb);
                5: ri = '0;
                default: ri = ins_t'($urandom);
            endcase
            rst_i = ($urandom_range(0, 39) == 0);
            drive(ri, 1'($urandom_range(0, 1)));
            check_model();
            advance();
        end
        rst_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
